mem_wb_pipe: RTL and testbench

- Parametrised Memory→Writeback pipeline block for the 16-bit pipelined CPU. Successor to the single fixed-width Memory/Writeback register.
- Carries memory and ALU results through WB_DEPTH register stages and performs the writeback select on registered values.
- Adds valid tracking, stall, flush, a youngest-first forwarding lookup for the hazard unit, and an optional retire counter.

---
 rtl/cpu_pipe_pkg.sv | 26 ++
 rtl/mux_2.sv | 19 +
 rtl/wb_slot_reg.sv | 38 +++
 rtl/mem_wb_pipe.sv | 122 ++++++++++++
 tb/tb_mem_wb_pipe.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : cpu_pipe_pkg                                                     |
// | Shared constants and the Memory/Writeback slot layout for the 16-bit CPU.  |
// | Revision: 1.0  initial parametrised release                                |
// +----------------------------------------------------------------------------+
package cpu_pipe_pkg;

  localparam logic WBS_ALU = 1'b1;
  localparam logic WBS_MEM = 1'b0;

  localparam int unsigned DEFAULT_DATA_W  = 16;
  localparam int unsigned DEFAULT_RADDR_W = 4;

  // valid is the MSB so stage registers can clear it without knowing the layout
  typedef struct packed {
    logic                       valid;
    logic                       regwrite;
    logic                       wbs;
    logic [DEFAULT_RADDR_W-1:0] rd;
    logic [DEFAULT_DATA_W-1:0]  mem_data;
    logic [DEFAULT_DATA_W-1:0]  alu_result;
  } wb_slot_t;

endpackage
`default_nettype wire

// File: rtl/mux_2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mux_2                                                            |
// | Generic two-input multiplexer: y = sel ? d1 : d0.                          |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module mux_2 #(
  parameter int unsigned W = 16
) (
  input  logic         sel,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  output logic [W-1:0] y
);

  assign y = sel ? d1 : d0;

endmodule
`default_nettype wire

// File: rtl/wb_slot_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : wb_slot_reg                                                      |
// | One Memory/Writeback stage register with stall, flush and async reset.     |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module wb_slot_reg
  import cpu_pipe_pkg::*;
#(
  parameter type SLOT_T = wb_slot_t
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  stall_i,
  input  logic  flush_i,
  input  SLOT_T slot_i,
  output SLOT_T slot_o
);

  localparam int unsigned C_SLOT_W = $bits(SLOT_T);

  SLOT_T r_slot;

  // Flush drops only the valid bit (MSB); payload is held for the mux.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot <= '0;
    end else if (flush_i) begin
      r_slot <= {1'b0, r_slot[C_SLOT_W-2:0]};
    end else if (!stall_i) begin
      r_slot <= slot_i;
    end
  end

  assign slot_o = r_slot;

endmodule
`default_nettype wire

// File: rtl/mem_wb_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mem_wb_pipe                                                      |
// | WB_DEPTH-stage Memory->Writeback pipe with registered writeback select,    |
// | stall/flush, youngest-first forwarding lookup. Optional retire counter     |
// | enabled by defining RETIRE_CNT_EN.                                         |
// | Revision: 1.0  initial parametrised release                                |
// +----------------------------------------------------------------------------+
module mem_wb_pipe
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned DATA_W   = DEFAULT_DATA_W,
  parameter int unsigned RADDR_W  = DEFAULT_RADDR_W,
  parameter int unsigned WB_DEPTH = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic               valid_m,
  input  logic               wbs_m,
  input  logic               regwrite_m,
  input  logic [RADDR_W-1:0] rd_m,
  input  logic [DATA_W-1:0]  mem_data_m,
  input  logic [DATA_W-1:0]  alu_result_m,
  input  logic [RADDR_W-1:0] src_rd_i,
  output logic               valid_w,
  output logic               regwrite_w,
  output logic [RADDR_W-1:0] rd_w,
  output logic [DATA_W-1:0]  wb_data_w,
  output logic               fwd_hit_o,
  output logic [DATA_W-1:0]  fwd_data_o,
  output logic [31:0]        retired_o
);

  typedef struct packed {
    logic               valid;
    logic               regwrite;
    logic               wbs;
    logic [RADDR_W-1:0] rd;
    logic [DATA_W-1:0]  mem_data;
    logic [DATA_W-1:0]  alu_result;
  } slot_t;

  localparam int unsigned C_LAST = WB_DEPTH - 1;

  if (WB_DEPTH < 1 || WB_DEPTH > 4) begin : g_bad_depth
    $error("mem_wb_pipe: WB_DEPTH must be within 1..4");
  end

  if (WBS_ALU == WBS_MEM) begin : g_bad_wbs
    $error("mem_wb_pipe: WBS_ALU and WBS_MEM must differ");
  end

  slot_t             w_stage_d  [WB_DEPTH];
  slot_t             w_stage_q  [WB_DEPTH];
  logic [DATA_W-1:0] w_sel_data [WB_DEPTH];

  for (genvar k = 0; k < WB_DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign w_stage_d[k] = {valid_m, regwrite_m, wbs_m, rd_m, mem_data_m, alu_result_m};
    end else begin : g_tail
      assign w_stage_d[k] = w_stage_q[k-1];
    end

    wb_slot_reg #(
      .SLOT_T (slot_t)
    ) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .stall_i (stall_i),
      .flush_i (flush_i),
      .slot_i  (w_stage_d[k]),
      .slot_o  (w_stage_q[k])
    );

    // Per-stage select feeds both writeback and forwarding.
    mux_2 #(
      .W (DATA_W)
    ) u_sel (
      .sel (w_stage_q[k].wbs == WBS_ALU),
      .d0  (w_stage_q[k].mem_data),
      .d1  (w_stage_q[k].alu_result),
      .y   (w_sel_data[k])
    );
  end

  assign valid_w    = w_stage_q[C_LAST].valid;
  assign regwrite_w = w_stage_q[C_LAST].valid & w_stage_q[C_LAST].regwrite;
  assign rd_w       = w_stage_q[C_LAST].rd;
  assign wb_data_w  = w_sel_data[C_LAST];

  // Walk oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    fwd_hit_o  = 1'b0;
    fwd_data_o = '0;
    for (int k = WB_DEPTH - 1; k >= 0; k--) begin
      if (w_stage_q[k].valid && w_stage_q[k].regwrite && (w_stage_q[k].rd == src_rd_i)) begin
        fwd_hit_o  = 1'b1;
        fwd_data_o = w_sel_data[k];
      end
    end
  end

`ifdef RETIRE_CNT_EN
  logic [31:0] r_retired;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retired <= '0;
    end else if (regwrite_w && !stall_i) begin
      r_retired <= r_retired + 32'd1;
    end
  end

  assign retired_o = r_retired;
`else
  assign retired_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_mem_wb_pipe                                                   |
// | Scoreboard bench for mem_wb_pipe at WB_DEPTH=3 (RETIRE_CNT_EN aware).      |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_mem_wb_pipe;

  localparam int unsigned D = 3;

  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic        wbs;
    logic [3:0]  rd;
    logic [15:0] mem;
    logic [15:0] alu;
  } slot_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i, flush_i, valid_m, wbs_m, regwrite_m;
  logic [3:0]  rd_m, src_rd_i, rd_w;
  logic [15:0] mem_data_m, alu_result_m, wb_data_w, fwd_data_o;
  logic        valid_w, regwrite_w, fwd_hit_o;
  logic [31:0] retired_o;

  slot_t       pipe_q[$];
  slot_t       cur;
  int          edge_kind;
  logic [31:0] exp_retired;
  int          n_vec = 0;
  int          n_err = 0;

  mem_wb_pipe #(.DATA_W(16), .RADDR_W(4), .WB_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
    .valid_m(valid_m), .wbs_m(wbs_m), .regwrite_m(regwrite_m), .rd_m(rd_m),
    .mem_data_m(mem_data_m), .alu_result_m(alu_result_m), .src_rd_i(src_rd_i),
    .valid_w(valid_w), .regwrite_w(regwrite_w), .rd_w(rd_w), .wb_data_w(wb_data_w),
    .fwd_hit_o(fwd_hit_o), .fwd_data_o(fwd_data_o), .retired_o(retired_o)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] sel_data(slot_t s);
    return s.wbs ? s.alu : s.mem;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    pipe_q.delete();
    for (int i = 0; i < int'(D) - 1; i++) pipe_q.push_back('0);
    cur         = '0;
    edge_kind   = 0;
    exp_retired = '0;
  endtask

  // Stimulus side: every advancing edge pushes the issued slot.
  always @(posedge clk) begin
    if (rst_n && !stall_i && cur.valid && cur.regwrite) exp_retired = exp_retired + 32'd1;
    if (!rst_n)        edge_kind = 0;
    else if (flush_i)  edge_kind = 2;
    else if (stall_i)  edge_kind = 0;
    else begin
      edge_kind = 1;
      pipe_q.push_back({valid_m, regwrite_m, wbs_m, rd_m, mem_data_m, alu_result_m});
    end
  end

  // Monitor: retire the oldest expected slot and compare every output.
  always @(negedge clk) begin
    logic        e_hit;
    logic [15:0] e_fd;
    if (edge_kind == 1) begin
      cur = pipe_q.pop_front();
    end else if (edge_kind == 2) begin
      cur.valid = 1'b0;
      for (int i = 0; i < pipe_q.size(); i++) pipe_q[i].valid = 1'b0;
    end
    edge_kind = 0;
    e_hit = 1'b0;
    e_fd  = '0;
    if (cur.valid && cur.regwrite && cur.rd == src_rd_i) begin
      e_hit = 1'b1; e_fd = sel_data(cur);
    end
    for (int i = 0; i < pipe_q.size(); i++) begin
      if (pipe_q[i].valid && pipe_q[i].regwrite && pipe_q[i].rd == src_rd_i) begin
        e_hit = 1'b1; e_fd = sel_data(pipe_q[i]);
      end
    end
    chk("mon_valid_w",    32'(valid_w),    32'(cur.valid));
    chk("mon_regwrite_w", 32'(regwrite_w), 32'(cur.valid & cur.regwrite));
    chk("mon_rd_w",       32'(rd_w),       32'(cur.rd));
    chk("mon_wb_data_w",  32'(wb_data_w),  32'(sel_data(cur)));
    chk("mon_fwd_hit",    32'(fwd_hit_o),  32'(e_hit));
    chk("mon_fwd_data",   32'(fwd_data_o), 32'(e_fd));
`ifdef RETIRE_CNT_EN
    chk("mon_retired",    retired_o,       exp_retired);
`else
    chk("mon_retired",    retired_o,       32'd0);
`endif
  end

  task automatic issue(logic v, logic rw, logic wbs, logic [3:0] rd, logic [15:0] mem, logic [15:0] alu);
    valid_m = v; regwrite_m = rw; wbs_m = wbs; rd_m = rd; mem_data_m = mem; alu_result_m = alu;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue(1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000);
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_valid_w"},    32'(valid_w),    32'd0);
    chk({tag, "_regwrite_w"}, 32'(regwrite_w), 32'd0);
    chk({tag, "_rd_w"},       32'(rd_w),       32'd0);
    chk({tag, "_wb_data_w"},  32'(wb_data_w),  32'd0);
    chk({tag, "_fwd_hit"},    32'(fwd_hit_o),  32'd0);
    chk({tag, "_fwd_data"},   32'(fwd_data_o), 32'd0);
    chk({tag, "_retired"},    retired_o,       32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0; src_rd_i = 4'd0;
    valid_m = 1'b0; regwrite_m = 1'b0; wbs_m = 1'b0; rd_m = 4'd0;
    mem_data_m = '0; alu_result_m = '0;
    model_reset();
    #12;
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single store-to-register, ALU then memory select.
    issue(1'b1, 1'b1, 1'b1, 4'd14, 16'h0DB2, 16'h000E);
    issue(1'b1, 1'b1, 1'b0, 4'd14, 16'h0DB2, 16'h000E);
    idle();
    chk("alu_sel_data", 32'(wb_data_w),  32'h000E);
    chk("alu_sel_rd",   32'(rd_w),       32'd14);
    chk("alu_sel_rw",   32'(regwrite_w), 32'd1);
    idle();
    chk("mem_sel_data", 32'(wb_data_w),  32'h0DB2);

    // Back-to-back results emerge in order after D edges.
    issue(1'b1, 1'b1, 1'b1, 4'd1, 16'h0000, 16'h0001);
    issue(1'b1, 1'b1, 1'b1, 4'd2, 16'h0000, 16'h0002);
    issue(1'b1, 1'b1, 1'b1, 4'd3, 16'h0000, 16'h0003);
    chk("b2b_first",  32'(wb_data_w), 32'h0001);
    idle();
    chk("b2b_second", 32'(wb_data_w), 32'h0002);
    idle();
    chk("b2b_third",  32'(wb_data_w), 32'h0003);
    chk("b2b_rd3",    32'(rd_w),      32'd3);

    // Two-cycle stall mid-stream; _m junk must be ignored.
    issue(1'b1, 1'b1, 1'b1, 4'd7, 16'h0000, 16'h0111);
    issue(1'b1, 1'b1, 1'b1, 4'd8, 16'h0000, 16'h0222);
    issue(1'b1, 1'b1, 1'b1, 4'd9, 16'h0000, 16'h0333);
    chk("stall_pre", 32'(wb_data_w), 32'h0111);
    stall_i = 1'b1;
    issue(1'b1, 1'b1, 1'b1, 4'd15, 16'hDEAD, 16'hDEAD);
    chk("stall_hold1", 32'(wb_data_w), 32'h0111);
    issue(1'b1, 1'b1, 1'b1, 4'd15, 16'hBEEF, 16'hBEEF);
    chk("stall_hold2", 32'(wb_data_w), 32'h0111);
    chk("stall_rd",    32'(rd_w),      32'd7);
    stall_i = 1'b0;
    idle();
    chk("stall_after", 32'(wb_data_w), 32'h0222);
    idle(); idle();

    // Flush together with stall kills everything in flight.
    src_rd_i = 4'd10;
    issue(1'b1, 1'b1, 1'b1, 4'd10, 16'h0000, 16'h0A0A);
    issue(1'b1, 1'b1, 1'b1, 4'd11, 16'h0000, 16'h0B0B);
    issue(1'b1, 1'b1, 1'b1, 4'd12, 16'h0000, 16'h0C0C);
    chk("preflush_hit", 32'(fwd_hit_o), 32'd1);
    stall_i = 1'b1; flush_i = 1'b1;
    issue(1'b1, 1'b1, 1'b1, 4'd10, 16'hDEAD, 16'hDEAD);
    chk("flush_regwrite", 32'(regwrite_w), 32'd0);
    chk("flush_fwd_hit",  32'(fwd_hit_o),  32'd0);
    stall_i = 1'b0; flush_i = 1'b0;
    idle(); idle(); idle();

    // Forwarding priority and qualification.
    src_rd_i = 4'd5;
    issue(1'b1, 1'b1, 1'b1, 4'd5, 16'h0000, 16'h5555);
    issue(1'b1, 1'b1, 1'b1, 4'd5, 16'h0000, 16'hAAAA);
    chk("fwd_young_hit",  32'(fwd_hit_o),  32'd1);
    chk("fwd_young_data", 32'(fwd_data_o), 32'hAAAA);
    src_rd_i = 4'd6;
    #1;
    chk("fwd_miss_hit",  32'(fwd_hit_o),  32'd0);
    chk("fwd_miss_data", 32'(fwd_data_o), 32'd0);
    src_rd_i = 4'd5;
    issue(1'b0, 1'b1, 1'b1, 4'd5, 16'h0000, 16'h1234);
    chk("fwd_bubble_skip", 32'(fwd_data_o), 32'hAAAA);
    issue(1'b1, 1'b0, 1'b0, 4'd5, 16'h7777, 16'h0000);
    chk("fwd_norw_skip",   32'(fwd_data_o), 32'hAAAA);
    src_rd_i = 4'd0;
    issue(1'b1, 1'b1, 1'b0, 4'd0, 16'h0F0F, 16'h0000);
    chk("fwd_r0_hit",  32'(fwd_hit_o),  32'd1);
    chk("fwd_r0_data", 32'(fwd_data_o), 32'h0F0F);
    idle(); idle(); idle();

    // Asynchronous reset between edges with a full pipe.
    issue(1'b1, 1'b1, 1'b1, 4'd1, 16'h0000, 16'h1111);
    issue(1'b1, 1'b1, 1'b1, 4'd2, 16'h0000, 16'h2222);
    issue(1'b1, 1'b1, 1'b1, 4'd3, 16'h0000, 16'h3333);
    src_rd_i = 4'd3;
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_all_zero("async_rst");
    valid_m = 1'b0; regwrite_m = 1'b0; wbs_m = 1'b0; rd_m = '0;
    mem_data_m = '0; alu_result_m = '0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    issue(1'b1, 1'b1, 1'b1, 4'd3, 16'h0000, 16'h3C3C);
    idle();
    chk("post_rst_early", 32'(valid_w), 32'd0);
    idle();
    chk("post_rst_data",  32'(wb_data_w), 32'h3C3C);
    chk("post_rst_rw",    32'(regwrite_w), 32'd1);
    idle(); idle();

`ifdef RETIRE_CNT_EN
    // One write already retired since reset; four more writes plus a bubble.
    issue(1'b1, 1'b1, 1'b1, 4'd4, 16'h0000, 16'h0004);
    issue(1'b1, 1'b1, 1'b1, 4'd5, 16'h0000, 16'h0005);
    issue(1'b0, 1'b1, 1'b1, 4'd6, 16'h0000, 16'h0006);
    issue(1'b1, 1'b1, 1'b1, 4'd7, 16'h0000, 16'h0007);
    issue(1'b1, 1'b1, 1'b1, 4'd8, 16'h0000, 16'h0008);
    idle(); idle(); idle();
    chk("retire_count", retired_o, 32'd5);
    issue(1'b1, 1'b1, 1'b1, 4'd2, 16'h0000, 16'h0001);
    idle(); idle();
    force dut.r_retired = 32'hFFFF_FFFF;
    exp_retired = 32'hFFFF_FFFF;
    #1;
    release dut.r_retired;
    idle();
    chk("retire_wrap", retired_o, 32'd0);
`endif

    idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
